// File: rtl/sb_tx_pkg.sv
// sb_tx_pkg: shared sideband TX defaults, serializer states and frame type
package sb_tx_pkg;
   localparam int SB_WORD_W = 64;
   localparam int SB_GAP_UI = 32;
   typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_GAP} sb_ser_state_e;
   typedef struct packed {
      logic                 last;
      logic [SB_WORD_W-1:0] data;
   } sb_frame_t;
endpackage

// File: rtl/sb_tx_serializer_if.sv
// sb_tx_serializer_if: frame push handshake between framers and the sideband serializer
// Signals: frame (W bits), frame_valid (push request), frame_last (final frame of packet), ready (buffer not full).
// Modports: master = framer side, slave = serializer side.
interface sb_tx_serializer_if import sb_tx_pkg::*; #(parameter int W = SB_WORD_W) ();
   logic [W-1:0] frame;
   logic         frame_valid;
   logic         frame_last;
   logic         ready;
   modport master (output frame, frame_valid, frame_last, input ready);
   modport slave (input frame, frame_valid, frame_last, output ready);
endinterface

// File: rtl/sb_tx_frame_fifo.sv
// sb_tx_frame_fifo: synchronous show-ahead FIFO with full/empty/count flags
// Ports: i_clk, i_rst (async, active-high); i_wr_en/i_wr_data push; i_rd_en pop;
//        o_rd_data head entry; o_full, o_empty, o_count occupancy.
module sb_tx_frame_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic [W-1:0]             i_wr_data,
   input  logic                     i_rd_en,
   output logic [W-1:0]             o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          wr, rd;
   assign wr        = i_wr_en && !o_full;
   assign rd        = i_rd_en && !o_empty;
   assign o_full    = o_count == (AW+1)'(DEPTH);
   assign o_empty   = o_count == '0;
   assign o_rd_data = mem[rd_ptr];
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr) mem[wr_ptr] <= i_wr_data;
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         o_count <= o_count + (AW+1)'(wr) - (AW+1)'(rd);
      end
endmodule

// File: rtl/sb_tx_serializer.sv
// sb_tx_serializer: buffers sideband frames and shifts them out LSB-first with a low idle gap after each
// Ports: i_clk, i_rst (async, active-high); tx (slave modport: frame/frame_valid/frame_last in, ready out);
//        o_txdata serial lane, o_clk_en forwarded-clock enable, o_packet_sent pulse on last bit of a last frame,
//        o_overflow pulse after a dropped push, o_busy buffer non-empty or serializer active.
// Build option SB_TX_SERIALIZER_STATS_EN adds saturating o_frame_cnt[15:0] and o_drop_cnt[7:0].
module sb_tx_serializer import sb_tx_pkg::*; #(
   parameter int WORD_W     = SB_WORD_W,
   parameter int GAP_UI     = SB_GAP_UI,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   sb_tx_serializer_if.slave tx,
   output logic              o_txdata,
   output logic              o_clk_en,
   output logic              o_packet_sent,
   output logic              o_overflow,
   output logic              o_busy
`ifdef SB_TX_SERIALIZER_STATS_EN
   ,
   output logic [15:0]       o_frame_cnt,
   output logic [7:0]        o_drop_cnt
`endif
);
   localparam int BW = $clog2(WORD_W);
   localparam int GW = $clog2(GAP_UI) + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
   localparam logic [BW-1:0] BIT_PEN  = BW'(WORD_W - 2);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_UI - 1);
   sb_ser_state_e     state, state_n;
   logic [WORD_W-1:0] shreg, shreg_n;
   logic [BW-1:0]     bit_cnt, bit_cnt_n;
   logic [GW-1:0]     gap_cnt, gap_cnt_n;
   logic [WORD_W:0]   head;
   logic [CW-1:0]     count;
   logic              last_q, last_n, txdata_n, clk_en_n, pop, full, empty, frame_done, drop;
   assign tx.ready   = !full;
   assign drop       = tx.frame_valid && full;
   // registered pulses land together with bit WORD_W-1, so they are armed one bit earlier
   assign frame_done = state == SER_SHIFT && bit_cnt == BIT_PEN;
   assign o_busy     = count != '0 || state != SER_IDLE;
   sb_tx_frame_fifo #(.W(WORD_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (tx.frame_valid && !full),
      .i_wr_data ({tx.frame_last, tx.frame}),
      .i_rd_en   (pop),
      .o_rd_data (head),
      .o_full    (full),
      .o_empty   (empty),
      .o_count   (count)
   );
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      gap_cnt_n = gap_cnt;
      last_n    = last_q;
      txdata_n  = 1'b0;
      clk_en_n  = 1'b0;
      pop       = 1'b0;
      case (state)
         SER_IDLE: pop = !empty;
         SER_SHIFT:
            if (bit_cnt == BIT_LAST) begin
               state_n   = SER_GAP;
               gap_cnt_n = '0;
            end else begin
               shreg_n   = shreg >> 1;
               bit_cnt_n = bit_cnt + BW'(1);
               txdata_n  = shreg[1];
               clk_en_n  = 1'b1;
            end
         SER_GAP:
            if (gap_cnt == GAP_LAST) begin
               pop     = !empty;
               state_n = SER_IDLE;
            end else gap_cnt_n = gap_cnt + GW'(1);
         default: state_n = SER_IDLE;
      endcase
      // a pop from IDLE or from the end of the gap starts the next frame with no bubble
      if (pop) begin
         state_n   = SER_SHIFT;
         shreg_n   = head[WORD_W-1:0];
         last_n    = head[WORD_W];
         bit_cnt_n = '0;
         txdata_n  = head[0];
         clk_en_n  = 1'b1;
      end
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state         <= SER_IDLE;
         shreg         <= '0;
         bit_cnt       <= '0;
         gap_cnt       <= '0;
         last_q        <= 1'b0;
         o_txdata      <= 1'b0;
         o_clk_en      <= 1'b0;
         o_packet_sent <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         state         <= state_n;
         shreg         <= shreg_n;
         bit_cnt       <= bit_cnt_n;
         gap_cnt       <= gap_cnt_n;
         last_q        <= last_n;
         o_txdata      <= txdata_n;
         o_clk_en      <= clk_en_n;
         o_packet_sent <= frame_done && last_q;
         o_overflow    <= drop;
      end
`ifdef SB_TX_SERIALIZER_STATS_EN
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         o_frame_cnt <= '0;
         o_drop_cnt  <= '0;
      end else begin
         if (frame_done && o_frame_cnt != '1) o_frame_cnt <= o_frame_cnt + 16'd1;
         if (drop && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 8'd1;
      end
`endif
endmodule
